hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline interlock controller for the 3-stage pipelined CPU (fetch register → decode register → execute/writeback register). It keeps a scoreboard of architectural registers with an in-flight write and stalls fetch/PC while a decoded instruction reads one of them. It also injects bubbles into the decode register and covers the post-reset start-up window of the synchronous program memory.

## Interface
- NUM_REGS, 16: architectural registers tracked (register file depth)
- RADDR_W, 5: register-index width
- WB_LATENCY, 2: issue edge to register-file write edge, in cycles; legal range 1–4
- BOOT_CYCLES, 2: bubble cycles after reset release (memory read plus fetch register)
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low; all state cleared while low
- dec_valid  input  1  decode stage holds a real instruction
- dec_rs1  input  RADDR_W  source 1 index
- dec_rs2  input  RADDR_W  source 2 index
- dec_use_rs1  input  1  instruction reads rs1
- dec_use_rs2  input  1  instruction reads rs2
- dec_rd  input  RADDR_W  destination index
- dec_wen  input  1  instruction writes rd
- stall  output  1  hold PC and fetch register this cycle
- bubble  output  1  force decode-register reg_wr_en to 0 this cycle
- issue  output  1  the decoded instruction enters the decode register at the next edge
- pending  output  NUM_REGS  scoreboard, bit i set means register i has a write in flight

## Operation
- State machine: BOOT, RUN, STALL. Reset enters BOOT with the boot counter at 0.
- BOOT: stall=1, bubble=1, issue=0. The counter increments each cycle. At BOOT_CYCLES-1 the FSM moves to RUN.
- Hazard: `hz = dec_valid & ((dec_use_rs1 & pending[dec_rs1]) | (dec_use_rs2 & pending[dec_rs2]))`. Indices 0 and indices ≥ NUM_REGS never hit.
- RUN: with hz=0, issue = dec_valid and stall = bubble = 0. With hz=1, stall=1, bubble=1, issue=0, and the FSM goes to STALL.
- STALL: outputs as in RUN with hz=1. The FSM returns to RUN in the cycle hz drops. Issue happens in that same cycle.
- Retire shift register: WB_LATENCY entries of {valid, rd}. At every edge, entry 0 loads {issue & dec_wen & rd valid, dec_rd} and the other entries shift. Bubbles shift in as invalid.
- Scoreboard at each edge:
  - Set bit dec_rd when issue & dec_wen.
  - Clear the bit named by the last shift entry when that entry is valid.
  - If set and clear hit the same register in the same edge, set wins (a newer writer is in flight).
- Writes to register 0 and to indices ≥ NUM_REGS are never recorded.
- dec_valid=0 produces no issue and no hazard, and the FSM stays in RUN.

## Timing
- All outputs are combinational from state, the scoreboard and the dec_* inputs. No output is registered.
- Reset values: stall=1, bubble=1, issue=0, pending=0, state BOOT, shift register all invalid.
- A producer issued at edge E0 sets pending at E0 and clears it at E0+WB_LATENCY. A dependent instruction waits at most WB_LATENCY cycles and issues in the cycle after the clear.
- Back-to-back dependent instructions with WB_LATENCY=2 give exactly 2 stall cycles.
- Reset asserted mid-stall: immediate return to BOOT with pending cleared. Dropped in-flight writes are acceptable because the datapath is also reset.

## Configuration
- HAZARD_STATS_EN defined: adds output stall_cycles (32 bits, reset 0). It increments in every cycle where state is STALL or RUN with hz=1, and saturates at all-ones. BOOT cycles are not counted.
- HAZARD_STATS_EN undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- cpu_pkg holds the hz_state_t enum (BOOT, RUN, STALL), NUM_REGS_C = 16 and RADDR_W_C = 5.
- One sub-module, retire_shift: the WB_LATENCY-deep {valid, rd} delay line with a registered output.
- Scoreboard, FSM and hazard compare stay in hazard_ctrl.

## Test plan
- Reset release: stall=bubble=1 for exactly 2 cycles, then 0 with issue following dec_valid, and pending=0.
- Sequence ADD x3 ← …, then ADD x4 ← x3: pending[3] is set, stall=1 for 2 cycles, the consumer issues on the 3rd cycle, and pending[3] clears at the same edge.
- Independent sequence writing x5 then reading x6, x7: stall is never asserted and pending[5] pulses for 2 cycles.
- Write to x0, then read x0: pending stays 0 and there is no stall.
- WAW on x8 in consecutive instructions: pending[8] stays set until the second write retires, because set wins over clear.
- Reset driven low during STALL: outputs return to their reset values asynchronously. With HAZARD_STATS_EN defined, stall_cycles reads 0 afterwards and reads 2 after the RAW scenario.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and sizing for the CPU pipeline control blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } hz_state_t;

    localparam int NUM_REGS_C = 16;
    localparam int RADDR_W_C  = 5;

endpackage

// File: rtl/retire_shift.sv
// Delay line of {valid, rd} tags tracking register writes in flight to writeback.
// Latency: DEPTH cycles from i_vld/i_dat to o_vld/o_dat (output is registered).
// Backpressure: none; shifts every cycle, empty slots travel as invalid.
module retire_shift #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    logic [DEPTH-1:0] r_vld;
    logic [W-1:0]     r_dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_dat[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_dat = r_dat[DEPTH-1];

endmodule

// File: rtl/hazard_ctrl.sv
// RAW interlock: scoreboard of in-flight writes, stalls fetch while decode reads one; optional HAZARD_STATS_EN stall counter.
// Latency: all outputs combinational from state, scoreboard and dec_* inputs.
// Backpressure: stall/bubble held while a source is pending and for BOOT_CYCLES after reset.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_C,
    parameter int RADDR_W     = RADDR_W_C,
    parameter int WB_LATENCY  = 2,
    parameter int BOOT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [RADDR_W-1:0]  dec_rs1,
    input  logic [RADDR_W-1:0]  dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [RADDR_W-1:0]  dec_rd,
    input  logic                dec_wen,
    output logic                stall,
    output logic                bubble,
    output logic                issue,
    output logic [NUM_REGS-1:0] pending
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    hz_state_t           r_state;
    hz_state_t           w_state_nxt;
    logic [BCW-1:0]      r_boot_cnt;
    logic [NUM_REGS-1:0] r_pending;

    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_hz;
    logic [NUM_REGS-1:0] w_rd_onehot;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic                w_rd_ok;
    logic                w_ret_vld;
    logic [RADDR_W-1:0]  w_ret_dat;

    // Index 0 is hardwired zero and out-of-range indices are never tracked,
    // so the loops start at 1 and stop at NUM_REGS-1.
    always_comb begin
        w_rs1_hit   = 1'b0;
        w_rs2_hit   = 1'b0;
        w_rd_onehot = '0;
        w_clr_mask  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (dec_rs1 == RADDR_W'(i)) w_rs1_hit = r_pending[i];
            if (dec_rs2 == RADDR_W'(i)) w_rs2_hit = r_pending[i];
            if (dec_rd == RADDR_W'(i))  w_rd_onehot[i] = 1'b1;
            if (w_ret_dat == RADDR_W'(i)) w_clr_mask[i] = w_ret_vld;
        end
    end

    assign w_hz = dec_valid & ((dec_use_rs1 & w_rs1_hit) | (dec_use_rs2 & w_rs2_hit));

    always_comb begin
        stall       = 1'b1;
        bubble      = 1'b1;
        issue       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            BOOT: begin
                if (r_boot_cnt == BCW'(BOOT_CYCLES - 1)) w_state_nxt = RUN;
            end
            RUN, STALL: begin
                if (w_hz) begin
                    w_state_nxt = STALL;
                end else begin
                    stall       = 1'b0;
                    bubble      = 1'b0;
                    issue       = dec_valid;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    assign w_rd_ok    = |w_rd_onehot;
    assign w_set_mask = w_rd_onehot & {NUM_REGS{issue & dec_wen}};

    retire_shift #(
        .DEPTH (WB_LATENCY),
        .W     (RADDR_W)
    ) u_retire_shift (
        .clk   (clk),
        .rst_n (reset),
        .i_vld (issue & dec_wen & w_rd_ok),
        .i_dat (dec_rd),
        .o_vld (w_ret_vld),
        .o_dat (w_ret_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_boot_cnt <= '0;
            r_pending  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == BOOT) r_boot_cnt <= r_boot_cnt + BCW'(1);
            // A newer writer to the retiring register keeps its bit set.
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign pending = r_pending;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if ((r_state != BOOT) && w_hz && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven check of hazard_ctrl: boot window, RAW stalls, scoreboard set/clear, reset mid-stall.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic [4:0]  dec_rd;
    logic        dec_wen;
    logic        stall;
    logic        bubble;
    logic        issue;
    logic [15:0] pending;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(
        .NUM_REGS    (16),
        .RADDR_W     (5),
        .WB_LATENCY  (2),
        .BOOT_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_rd      (dec_rd),
        .dec_wen     (dec_wen),
        .stall       (stall),
        .bubble      (bubble),
        .issue       (issue),
        .pending     (pending)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        wen;
        logic        e_stall;
        logic        e_bubble;
        logic        e_issue;
        logic [15:0] e_pend;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [NV];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd, input logic wen,
                                input logic es, input logic eb, input logic ei, input int ep);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = 5'(rd); r.wen = wen;
        r.e_stall = es; r.e_bubble = eb; r.e_issue = ei; r.e_pend = 16'(ep);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2,
                         input logic u1, input logic u2, input int rd, input logic wen);
        dec_valid = v; dec_rs1 = 5'(rs1); dec_rs2 = 5'(rs2);
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_rd = 5'(rd); dec_wen = wen;
    endtask

    task automatic chk_out(input string tag, input logic es, input logic eb,
                           input logic ei, input logic [15:0] ep);
        chk({tag, ".stall"},   32'(stall),   32'(es));
        chk({tag, ".bubble"},  32'(bubble),  32'(eb));
        chk({tag, ".issue"},   32'(issue),   32'(ei));
        chk({tag, ".pending"}, 32'(pending), 32'(ep));
    endtask

    initial begin
        // Boot window, then RAW on x3 (2 stalls), independent x5 write, x0 write/read,
        // WAW on x8 where set and clear collide, x20 out of range, rs2-only hazard on x9.
        vt[0]  = mk(1, 1, 2, 1, 1, 3, 1,  1, 1, 0, 'h0000);
        vt[1]  = mk(1, 1, 2, 1, 1, 3, 1,  1, 1, 0, 'h0000);
        vt[2]  = mk(1, 1, 2, 1, 1, 3, 1,  0, 0, 1, 'h0000);
        vt[3]  = mk(1, 3, 1, 1, 1, 4, 1,  1, 1, 0, 'h0008);
        vt[4]  = mk(1, 3, 1, 1, 1, 4, 1,  1, 1, 0, 'h0008);
        vt[5]  = mk(1, 3, 1, 1, 1, 4, 1,  0, 0, 1, 'h0000);
        vt[6]  = mk(1, 6, 7, 1, 1, 5, 1,  0, 0, 1, 'h0010);
        vt[7]  = mk(1, 6, 7, 1, 1, 0, 0,  0, 0, 1, 'h0030);
        vt[8]  = mk(1, 6, 7, 1, 1, 0, 0,  0, 0, 1, 'h0020);
        vt[9]  = mk(1, 1, 2, 1, 1, 0, 1,  0, 0, 1, 'h0000);
        vt[10] = mk(1, 0, 0, 1, 1, 0, 0,  0, 0, 1, 'h0000);
        vt[11] = mk(1, 1, 2, 1, 1, 8, 1,  0, 0, 1, 'h0000);
        vt[12] = mk(1, 1, 0, 1, 0, 0, 0,  0, 0, 1, 'h0100);
        vt[13] = mk(1, 2, 0, 1, 0, 8, 1,  0, 0, 1, 'h0100);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 'h0100);
        vt[15] = mk(0, 8, 0, 1, 0, 8, 1,  0, 0, 0, 'h0100);
        vt[16] = mk(1, 8, 0, 1, 0, 0, 0,  0, 0, 1, 'h0000);
        vt[17] = mk(1, 1, 2, 1, 1, 20, 1, 0, 0, 1, 'h0000);
        vt[18] = mk(1, 20, 20, 1, 1, 0, 0, 0, 0, 1, 'h0000);
        vt[19] = mk(1, 1, 2, 1, 1, 9, 1,  0, 0, 1, 'h0000);
        vt[20] = mk(1, 9, 1, 0, 1, 0, 0,  0, 0, 1, 'h0200);
        vt[21] = mk(1, 1, 9, 0, 1, 0, 0,  1, 1, 0, 'h0200);
        vt[22] = mk(1, 1, 9, 0, 1, 0, 0,  0, 0, 1, 'h0000);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1, 1, 0, 16'h0000);
`ifdef HAZARD_STATS_EN
        chk("reset.stall_cycles", stall_cycles, 32'd0);
`endif
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].v, int'(vt[i].rs1), int'(vt[i].rs2), vt[i].u1, vt[i].u2,
                  int'(vt[i].rd), vt[i].wen);
            @(negedge clk);
            chk_out($sformatf("row%0d", i), vt[i].e_stall, vt[i].e_bubble,
                    vt[i].e_issue, vt[i].e_pend);
`ifdef HAZARD_STATS_EN
            if (i == 5) chk("raw.stall_cycles", stall_cycles, 32'd2);
`endif
            @(posedge clk);
            #1;
        end

        // Reset asserted while stalled on x3: outputs fall back without a clock edge.
        drive(1, 1, 2, 1, 1, 3, 1);
        @(negedge clk);
        chk_out("midrst.prod", 0, 0, 1, 16'h0000);
        @(posedge clk);
        #1;
        drive(1, 3, 0, 1, 0, 4, 1);
        @(negedge clk);
        chk_out("midrst.stall", 1, 1, 0, 16'h0008);
        #2;
        reset = 1'b0;
        #1;
        chk_out("midrst.async", 1, 1, 0, 16'h0000);
`ifdef HAZARD_STATS_EN
        chk("midrst.stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk_out("reboot0", 1, 1, 0, 16'h0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("reboot1", 1, 1, 0, 16'h0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("reboot.run", 0, 0, 1, 16'h0000);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_out("reboot.after", 0, 0, 0, 16'h0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
